bcd_hex_counter_n: RTL and testbench

Parametrised multi-digit up/down counter. It generalises the existing single-digit 4-bit counter to DIGITS nibbles, with run-time BCD/hex mode, synchronous load and clear, direction control, wrap or saturate policy, and terminal-count/overflow reporting. Each nibble of count feeds one existing hex_to_7seg instance at board top level. The clock is normally a debounced key or a divided system clock.

---
 rtl/bcd_hex_counter_n_pkg.sv | 12 +
 rtl/bcd_hex_counter_n_digit.sv | 56 +++++
 rtl/bcd_hex_counter_n.sv | 70 +++++++
 tb/tb_bcd_hex_counter_n.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_hex_counter_n_pkg.sv
// Shared digit constants and the per-mode digit maximum for the BCD/hex counter.
package bcd_hex_counter_n_pkg;

   localparam int         DIGIT_W = 4;
   localparam logic [3:0] HEX_MAX = 4'hF;
   localparam logic [3:0] BCD_MAX = 4'h9;

   function automatic logic [DIGIT_W-1:0] digit_max(input logic bcd);
      return bcd ? BCD_MAX : HEX_MAX;
   endfunction

endpackage

// File: rtl/bcd_hex_counter_n_digit.sv
// One 4-bit counter digit: steps when its carry-in is set and reports carry-out
// when it is at max (counting up) or at zero (counting down).
module bcd_hex_counter_n_digit
   import bcd_hex_counter_n_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               i_cin,
   input  logic               i_step,
   input  logic               i_up,
   input  logic               i_bcd,
   input  logic               i_clear,
   input  logic               i_load,
   input  logic [DIGIT_W-1:0] i_load_d,
   output logic [DIGIT_W-1:0] o_digit,
   output logic               o_cout
);

   logic [DIGIT_W-1:0] r_digit;
   logic [DIGIT_W-1:0] w_max;
   logic [DIGIT_W-1:0] w_down_base;
   logic [DIGIT_W-1:0] w_next;
   logic               w_at_top;
   logic               w_at_zero;

   assign w_max     = digit_max(i_bcd);
   // Loaded BCD values above 9 count as max so they roll over like a 9.
   assign w_at_top  = (r_digit >= w_max);
   assign w_at_zero = (r_digit == '0);
   assign o_cout    = i_cin & (i_up ? w_at_top : w_at_zero);
   assign o_digit   = r_digit;

   assign w_down_base = (i_bcd && r_digit > BCD_MAX) ? BCD_MAX : r_digit;

   always_comb begin
      // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
      w_next = r_digit;
      if (i_up)
         w_next = w_at_top ? '0 : r_digit + 4'd1;
      else
         w_next = w_at_zero ? w_max : w_down_base - 4'd1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         r_digit <= '0;
      else if (i_clear)
         r_digit <= '0;
      else if (i_load)
         r_digit <= i_load_d;
      else if (i_step && i_cin)
         r_digit <= w_next;
   end

endmodule

// File: rtl/bcd_hex_counter_n.sv
// Multi-digit BCD/hex up/down counter with load, clear, wrap/saturate policy,
// a one-cycle terminal-count pulse and a sticky overflow flag.
module bcd_hex_counter_n
   import bcd_hex_counter_n_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int SATURATE = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    up,
   input  logic                    bcd,
   input  logic                    clear,
   input  logic                    load,
   input  logic [DIGIT_W*DIGITS-1:0] load_value,
   output logic [DIGIT_W*DIGITS-1:0] count,
   output logic                    tc,
   output logic                    ovf
);

   logic [DIGITS:0] w_carry;
   logic            w_step;
   logic            w_term;
   logic            w_advance;
   logic            r_tc;
   logic            r_ovf;

   // Digit 0 always has carry-in; the last carry-out means every digit is terminal.
   assign w_carry[0] = 1'b1;
   assign w_term     = w_carry[DIGITS];
   assign w_step     = enable & ~clear & ~load;
   assign w_advance  = w_step & ~((SATURATE != 0) & w_term);

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_hex_counter_n_digit u_digit (
         .clock    (clock),
         .reset    (reset),
         .i_cin    (w_carry[g]),
         .i_step   (w_advance),
         .i_up     (up),
         .i_bcd    (bcd),
         .i_clear  (clear),
         .i_load   (load),
         .i_load_d (load_value[DIGIT_W*g +: DIGIT_W]),
         .o_digit  (count[DIGIT_W*g +: DIGIT_W]),
         .o_cout   (w_carry[g+1])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (clear) begin
         r_tc  <= 1'b0;
         r_ovf <= 1'b0;
      end else if (load) begin
         r_tc  <= 1'b0;
      end else begin
         r_tc <= w_step & w_term;
         if (w_step && w_term)
            r_ovf <= 1'b1;
      end
   end

   assign tc  = r_tc;
   assign ovf = r_ovf;

endmodule

// File: tb/tb_bcd_hex_counter_n.sv
// Directed bench: three counter instances (2-digit wrap, 3-digit wrap, 2-digit
// saturate) share controls; each check looks at the instance under test.
module tb_bcd_hex_counter_n;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        up = 1'b1;
   logic        bcd = 1'b1;
   logic        clear = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  lv2 = '0;
   logic [11:0] lv3 = '0;
   logic [7:0]  count2, count_s;
   logic [11:0] count3;
   logic        tc2, ovf2, tc3, ovf3, tc_s, ovf_s;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_hex_counter_n #(.DIGITS(2), .SATURATE(0)) dut2 (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .bcd(bcd),
      .clear(clear), .load(load), .load_value(lv2),
      .count(count2), .tc(tc2), .ovf(ovf2));

   bcd_hex_counter_n #(.DIGITS(3), .SATURATE(0)) dut3 (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .bcd(bcd),
      .clear(clear), .load(load), .load_value(lv3),
      .count(count3), .tc(tc3), .ovf(ovf3));

   bcd_hex_counter_n #(.DIGITS(2), .SATURATE(1)) dut_s (
      .clock(clock), .reset(reset), .enable(enable), .up(up), .bcd(bcd),
      .clear(clear), .load(load), .load_value(lv2),
      .count(count_s), .tc(tc_s), .ovf(ovf_s));

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset state
      #2;
      check("rst_count", 32'(count2), 32'h0);
      check("rst_tc",    32'(tc2),    32'h0);
      check("rst_ovf",   32'(ovf2),   32'h0);

      // Release between edges, then count up in BCD
      @(negedge clock);
      reset  = 1'b1;
      bcd    = 1'b1;
      up     = 1'b1;
      enable = 1'b1;
      for (int i = 0; i < 99; i++) tick();
      check("bcd99_count", 32'(count2), 32'h99);
      check("bcd99_tc",    32'(tc2),    32'h0);
      check("bcd99_ovf",   32'(ovf2),   32'h0);
      check("bcd99_3dig",  32'(count3), 32'h099);

      tick();
      check("wrap_count",  32'(count2),  32'h00);
      check("wrap_tc",     32'(tc2),     32'h1);
      check("wrap_ovf",    32'(ovf2),    32'h1);
      check("sat_count",   32'(count_s), 32'h99);
      check("sat_tc",      32'(tc_s),    32'h1);
      check("sat_ovf",     32'(ovf_s),   32'h1);

      enable = 1'b0;
      tick();
      check("idle_tc",     32'(tc2),     32'h0);
      check("idle_ovf",    32'(ovf2),    32'h1);
      check("idle_count",  32'(count2),  32'h00);
      check("idle_sat_tc", 32'(tc_s),    32'h0);

      enable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("sat_hold_count", 32'(count_s), 32'h99);
         check("sat_hold_tc",    32'(tc_s),    32'h1);
      end

      // Hex down from zero wraps to FF
      enable = 1'b0;
      clear  = 1'b1;
      tick();
      check("clr_count", 32'(count2), 32'h00);
      check("clr_ovf",   32'(ovf2),   32'h0);
      clear  = 1'b0;
      bcd    = 1'b0;
      up     = 1'b0;
      enable = 1'b1;
      tick();
      check("hexdn_count", 32'(count2), 32'hFF);
      check("hexdn_tc",    32'(tc2),    32'h1);
      check("hexdn_ovf",   32'(ovf2),   32'h1);
      enable = 1'b0;
      tick();
      check("hexdn_tc_end", 32'(tc2),    32'h0);
      check("hexdn_hold",   32'(count2), 32'hFF);
      clear = 1'b1;
      tick();
      check("clr2_count", 32'(count2), 32'h00);
      check("clr2_ovf",   32'(ovf2),   32'h0);

      // 3-digit load of 0A9 and BCD up step with invalid middle digit
      clear = 1'b0;
      bcd   = 1'b1;
      up    = 1'b1;
      load  = 1'b1;
      lv3   = 12'h0A9;
      tick();
      check("ld3_count", 32'(count3), 32'h0A9);
      load   = 1'b0;
      enable = 1'b1;
      tick();
      check("carry3_count", 32'(count3), 32'h100);
      check("carry3_tc",    32'(tc3),    32'h0);

      // Priority: clear > load > step
      clear = 1'b1;
      load  = 1'b1;
      lv2   = 8'h37;
      tick();
      check("prio_clr", 32'(count2), 32'h00);
      clear = 1'b0;
      tick();
      check("prio_ld",    32'(count2), 32'h37);
      check("prio_ld_tc", 32'(tc2),    32'h0);

      // BCD down with digit above 9, then a mid-count mode change
      lv2 = 8'h0C;
      tick();
      load = 1'b0;
      up   = 1'b0;
      tick();
      check("bcd_dn_gt9", 32'(count2), 32'h08);
      bcd = 1'b0;
      tick();
      check("mode_chg", 32'(count2), 32'h07);
      bcd  = 1'b1;
      load = 1'b1;
      lv2  = 8'h30;
      tick();
      load = 1'b0;
      tick();
      check("bcd_dn_borrow", 32'(count2), 32'h29);

      // Asynchronous reset in mid-cycle
      load = 1'b1;
      lv2  = 8'h99;
      up   = 1'b1;
      tick();
      load = 1'b0;
      tick();
      check("pre_rst_ovf", 32'(ovf2), 32'h1);
      tick();
      check("pre_rst_count", 32'(count2), 32'h01);
      #3 reset = 1'b0;
      #1;
      check("async_count", 32'(count2), 32'h00);
      check("async_tc",    32'(tc2),    32'h0);
      check("async_ovf",   32'(ovf2),   32'h0);
      reset = 1'b1;
      tick();
      check("post_rst_step", 32'(count2), 32'h01);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
